mips_cpu_bus_lsu: RTL
=====================

# mips_cpu_bus_lsu

Load/store unit between the MIPS CPU datapath and the Avalon-style CPU bus that the test-bench memory serves. It turns one decoded load/store into a single word-aligned bus transaction with the correct byteenable lanes, honours waitrequest, and returns the aligned, sign/zero-extended or merged load result. All MIPS32 byte, half and word loads/stores are supported, including LWL/LWR, on a little-endian byte order.

## Interface
- No parameters.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately
- start  input  1  request strobe; sampled only while busy=0
- op  input  4  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWL 6=LWR 8=SB 9=SH 10=SW; others invalid
- address  input  32  byte address of access
- store_data  input  32  rt value for stores
- reg_old  input  32  current rt value, merge source for LWL/LWR
- busy  output  1  high from accepted start until done cycle inclusive
- done  output  1  one-cycle pulse: operation finished
- load_result  output  32  final rt value for loads; valid with done, held until next start
- addr_error  output  1  high with done when the op was misaligned/invalid
- bus_address  output  32  address & 32'hFFFF_FFFC
- bus_read / bus_write  output  1 each  bus strobes, never both high
- bus_byteenable  output  4  lane i = byte at bus_address+i = data[8i+7:8i]
- bus_writedata  output  32  store data placed on enabled lanes
- bus_waitrequest  input  1  slave stall
- bus_readdata  input  32  valid in the cycle after request acceptance

## Operation
- States: IDLE, REQ, DATA, DONE. All outputs registered.
- IDLE: start=1 latches op/address/store_data/reg_old, k=address[1:0]. Misaligned (LH/LHU/SH with k[0]=1; LW/SW with k!=0) or invalid op -> DONE with addr_error=1, no bus strobe. Otherwise -> REQ.
- REQ: bus_read (loads) or bus_write (stores) high with address/byteenable/writedata stable. Accepted on an edge where waitrequest=0. Load -> DATA; store -> DONE. Waitrequest=1 holds REQ, all bus outputs unchanged.
- DATA: capture bus_readdata, compute load_result -> DONE.
- DONE: done=1 for one cycle -> IDLE. start during busy is ignored (not queued).
- Byteenable: LB/LBU/SB one-hot 1<<k; LH/LHU/SH 0011 (k=0) or 1100 (k=2); LW/SW 1111; LWL k=0..3: 0001,0011,0111,1111; LWR k=0..3: 1111,1110,1100,1000.
- Store data: SB {4{store_data[7:0]}}, SH {2{store_data[15:0]}}, SW store_data.
- Loads, W=captured word, only enabled lanes used: LB/LBU byte W[8k+7:8k] sign/zero-extended; LH/LHU half W[8k+15:8k] extended; LW W.
- LWL: k=0 {W[7:0],reg_old[23:0]}; 1 {W[15:0],reg_old[15:0]}; 2 {W[23:0],reg_old[7:0]}; 3 W.
- LWR: k=0 W; 1 {reg_old[31:24],W[31:8]}; 2 {reg_old[31:16],W[31:16]}; 3 {reg_old[31:8],W[31:24]}.
- Stores and errors leave load_result unchanged.

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-transaction drops bus_read/bus_write asynchronously; no done issued for the aborted op.
- start sampled at edge 0 -> bus strobe high from edge 0.
- Load, zero wait: accepted edge 1, data captured edge 2, done high edge 2..3. Each waitrequest cycle adds one.
- Store, zero wait: accepted edge 1, done high edge 1..2.
- Error: done+addr_error high edge 0..1; bus strobes stay 0.
- Back-to-back: next start accepted in the cycle after done (IDLE), i.e. start high during done is ignored.
- Outside REQ, bus_read=bus_write=0; byteenable/address may hold last values.

## Test plan
- Memory word at 0x100 = 0x8899AABB: LB 0x101 -> byteenable 0010, load_result 0xFFFFFFAA; LBU 0x103 -> 0x00000088; LH 0x102 -> byteenable 1100, 0xFFFF8899; LW 0x100 -> 0x8899AABB, done 2 cycles after start.
- LWL 0x101 with reg_old 0x11223344 -> byteenable 0011, result 0xAABB3344; LWR 0x101 -> byteenable 1110, result 0x118899AA.
- SB 0x102 data 0x000000CD -> bus_writedata 0xCDCDCDCD, byteenable 0100; then LW 0x100 -> 0x88CDAABB. SH 0x100 0x1234 -> 0011, readback 0x88CD1234.
- waitrequest held high 3 cycles on LW: bus outputs stable throughout, done exactly 3 cycles later than zero-wait case.
- LW 0x102, SH 0x101, op=7: done+addr_error same-cycle pulse, bus_read/bus_write never asserted, load_result unchanged.
- reset pulsed while in REQ: strobes 0 immediately, no done; start issued after reset completes normally.

Source files
------------

// File: rtl/mips_cpu_bus_lsu.sv
// ---------------------------------------------------------------------------
// mips_cpu_bus_lsu
//
// Load/store unit sitting between the MIPS datapath and an Avalon-style
// memory bus. Each accepted request becomes exactly one word-aligned bus
// transaction. Misaligned or undefined operations finish immediately with
// addr_error and never touch the bus. Byte order is little-endian: bus lane i
// carries the byte at bus_address+i on data[8i+7:8i].
//
// Ports
//   clk             system clock, all state updates on the rising edge
//   reset           asynchronous active-high reset
//   start           request strobe, only looked at while idle
//   op              0=LB 1=LBU 2=LH 3=LHU 4=LW 5=LWL 6=LWR 8=SB 9=SH 10=SW
//   address         byte address of the access
//   store_data      rt value for stores
//   reg_old         current rt value, merge source for LWL/LWR
//   busy            high from accepted start through the done cycle
//   done            one-cycle completion pulse
//   load_result     final rt value for loads, held until the next load
//   addr_error      high together with done for misaligned/invalid ops
//   bus_address     word-aligned bus address
//   bus_read        bus read strobe
//   bus_write       bus write strobe
//   bus_byteenable  active byte lanes
//   bus_writedata   store data replicated onto the lanes
//   bus_waitrequest slave stall
//   bus_readdata    read data, valid the cycle after the read is accepted
// ---------------------------------------------------------------------------
module mips_cpu_bus_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [31:0] reg_old,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        addr_error,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Decode helpers
    // -----------------------------------------------------------------------
    function automatic logic f_op_valid(input logic [3:0] o);
        case (o)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR,
            OP_SB, OP_SH, OP_SW: f_op_valid = 1'b1;
            default:             f_op_valid = 1'b0;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [3:0] o, input logic [1:0] k);
        case (o)
            OP_LH, OP_LHU, OP_SH: f_misaligned = k[0];
            OP_LW, OP_SW:         f_misaligned = (k != 2'd0);
            default:              f_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_byteenable(input logic [3:0] o, input logic [1:0] k);
        case (o)
            OP_LB, OP_LBU, OP_SB: f_byteenable = 4'b0001 << k;
            OP_LH, OP_LHU, OP_SH: f_byteenable = k[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         f_byteenable = 4'b1111;
            // LWL pulls the bytes from the word start up to the addressed byte
            OP_LWL: begin
                case (k)
                    2'd0:    f_byteenable = 4'b0001;
                    2'd1:    f_byteenable = 4'b0011;
                    2'd2:    f_byteenable = 4'b0111;
                    default: f_byteenable = 4'b1111;
                endcase
            end
            // LWR pulls the bytes from the addressed byte up to the word end
            OP_LWR:  f_byteenable = 4'b1111 << k;
            default: f_byteenable = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_writedata(input logic [3:0] o, input logic [31:0] d);
        case (o)
            OP_SB:   f_writedata = {4{d[7:0]}};
            OP_SH:   f_writedata = {2{d[15:0]}};
            default: f_writedata = d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [3:0] o, input logic [1:0] k,
                                           input logic [31:0] w, input logic [31:0] ro);
        logic [31:0] sh;
        // Bring the addressed byte down to lane 0 for the narrow loads
        sh = w >> {k, 3'b000};
        case (o)
            OP_LB:  f_load = {{24{sh[7]}}, sh[7:0]};
            OP_LBU: f_load = {24'd0, sh[7:0]};
            OP_LH:  f_load = {{16{sh[15]}}, sh[15:0]};
            OP_LHU: f_load = {16'd0, sh[15:0]};
            OP_LWL: begin
                case (k)
                    2'd0:    f_load = {w[7:0],  ro[23:0]};
                    2'd1:    f_load = {w[15:0], ro[15:0]};
                    2'd2:    f_load = {w[23:0], ro[7:0]};
                    default: f_load = w;
                endcase
            end
            OP_LWR: begin
                case (k)
                    2'd0:    f_load = w;
                    2'd1:    f_load = {ro[31:24], w[31:8]};
                    2'd2:    f_load = {ro[31:16], w[31:16]};
                    default: f_load = {ro[31:8],  w[31:24]};
                endcase
            end
            default: f_load = w;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_t      r_state,       r_state_next;
    logic [3:0]  r_op,          r_op_next;
    logic [1:0]  r_k,           r_k_next;
    logic [31:0] r_reg_old,     r_reg_old_next;
    logic        r_busy,        r_busy_next;
    logic        r_done,        r_done_next;
    logic        r_addr_error,  r_addr_error_next;
    logic [31:0] r_load_result, r_load_result_next;
    logic [31:0] r_bus_address, r_bus_address_next;
    logic        r_bus_read,    r_bus_read_next;
    logic        r_bus_write,   r_bus_write_next;
    logic [3:0]  r_bus_be,      r_bus_be_next;
    logic [31:0] r_bus_wd,      r_bus_wd_next;

    logic        w_req_bad;
    logic [3:0]  w_req_be;
    logic [31:0] w_req_wd;
    logic [31:0] w_load_value;

    assign w_req_bad    = !f_op_valid(op) || f_misaligned(op, address[1:0]);
    assign w_req_be     = f_byteenable(op, address[1:0]);
    assign w_req_wd     = f_writedata(op, store_data);
    assign w_load_value = f_load(r_op, r_k, bus_readdata, r_reg_old);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= 4'd0;
            r_k           <= 2'd0;
            r_reg_old     <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_addr_error  <= 1'b0;
            r_load_result <= 32'd0;
            r_bus_address <= 32'd0;
            r_bus_read    <= 1'b0;
            r_bus_write   <= 1'b0;
            r_bus_be      <= 4'd0;
            r_bus_wd      <= 32'd0;
        end else begin
            r_state       <= r_state_next;
            r_op          <= r_op_next;
            r_k           <= r_k_next;
            r_reg_old     <= r_reg_old_next;
            r_busy        <= r_busy_next;
            r_done        <= r_done_next;
            r_addr_error  <= r_addr_error_next;
            r_load_result <= r_load_result_next;
            r_bus_address <= r_bus_address_next;
            r_bus_read    <= r_bus_read_next;
            r_bus_write   <= r_bus_write_next;
            r_bus_be      <= r_bus_be_next;
            r_bus_wd      <= r_bus_wd_next;
        end
    end

    always_comb begin
        r_state_next       = r_state;
        r_op_next          = r_op;
        r_k_next           = r_k;
        r_reg_old_next     = r_reg_old;
        r_done_next        = 1'b0;
        r_addr_error_next  = 1'b0;
        r_load_result_next = r_load_result;
        r_bus_address_next = r_bus_address;
        r_bus_read_next    = 1'b0;
        r_bus_write_next   = 1'b0;
        r_bus_be_next      = r_bus_be;
        r_bus_wd_next      = r_bus_wd;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    r_op_next      = op;
                    r_k_next       = address[1:0];
                    r_reg_old_next = reg_old;
                    if (w_req_bad) begin
                        // Rejected ops complete at once without a bus cycle
                        r_state_next      = S_DONE;
                        r_done_next       = 1'b1;
                        r_addr_error_next = 1'b1;
                    end else begin
                        r_state_next       = S_REQ;
                        r_bus_address_next = {address[31:2], 2'b00};
                        r_bus_be_next      = w_req_be;
                        r_bus_wd_next      = w_req_wd;
                        r_bus_read_next    = !op[3];
                        r_bus_write_next   = op[3];
                    end
                end
            end
            S_REQ: begin
                if (bus_waitrequest) begin
                    r_bus_read_next  = r_bus_read;
                    r_bus_write_next = r_bus_write;
                end else if (r_op[3]) begin
                    r_state_next = S_DONE;
                    r_done_next  = 1'b1;
                end else begin
                    r_state_next = S_DATA;
                end
            end
            S_DATA: begin
                r_load_result_next = w_load_value;
                r_state_next       = S_DONE;
                r_done_next        = 1'b1;
            end
            default: begin
                r_state_next = S_IDLE;
            end
        endcase

        r_busy_next = (r_state_next != S_IDLE);
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign addr_error     = r_addr_error;
    assign load_result    = r_load_result;
    assign bus_address    = r_bus_address;
    assign bus_read       = r_bus_read;
    assign bus_write      = r_bus_write;
    assign bus_byteenable = r_bus_be;
    assign bus_writedata  = r_bus_wd;

endmodule
